// File: rtl/clk_meas_pkg.sv
// Shared types and defaults for the slow-clock measurement blocks.
// The FSM encoding and default widths are also reused by the clock divider bench.
package clk_meas_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MEAS = 2'd1,
    ST_STOP = 2'd2
  } meas_state_t;

  localparam int DEF_CNT_W   = 16;
  localparam int DEF_TIMEOUT = 60000;

endpackage

// File: rtl/sync_edge_det.sv
// Synchronises an asynchronous slow clock into clk_in and flags its rising edge.
// rise is a one-cycle pulse: the synced level is high and the history flop is still low.
module sync_edge_det #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk_in,
  input  logic reset_n,
  input  logic sig_in,
  output logic s,
  output logic rise
);

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_hist;

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      r_sync <= '0;
      r_hist <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], sig_in};
      r_hist <= r_sync[SYNC_STAGES-1];
    end
  end

  assign s    = r_sync[SYNC_STAGES-1];
  assign rise = s & ~r_hist;

endmodule

// File: rtl/clk_freq_meter.sv
// Measures the period (and optionally high time) of a slow clock in clk_in cycles.
// Define DUTY_MEASURE_EN to build the high-time counter; otherwise high_time is 0.
//
// state   | meaning
// IDLE    | waiting for the first rising edge after reset
// MEAS    | counting clk_in cycles since the last rising edge
// STOP    | no rising edge for TIMEOUT cycles; counter saturated
module clk_freq_meter
  import clk_meas_pkg::*;
#(
  parameter int CNT_W       = DEF_CNT_W,
  parameter int TIMEOUT     = DEF_TIMEOUT,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk_in,
  input  logic             reset_n,
  input  logic             sig_in,
  input  logic             meas_ready,
  output logic             meas_valid,
  output logic [CNT_W-1:0] period,
  output logic [CNT_W-1:0] high_time,
  output logic             stopped,
  output logic             dropped
);

  localparam logic [CNT_W-1:0] LP_TIMEOUT = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] LP_ONE     = CNT_W'(1);

  meas_state_t      r_state;
  meas_state_t      w_state_nxt;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] r_period;
  logic             r_valid;
  logic             r_dropped;
  logic             w_s;
  logic             w_rise;
  logic             w_at_limit;
  logic             w_count_en;
  logic             w_load;
  logic             w_drop;

  sync_edge_det #(
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync (
    .clk_in  (clk_in),
    .reset_n (reset_n),
    .sig_in  (sig_in),
    .s       (w_s),
    .rise    (w_rise)
  );

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  // A rise coinciding with the timeout is a valid edge, so it wins over stopping.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE: if (w_rise) w_state_nxt = ST_MEAS;
      ST_MEAS: if (!w_rise && w_at_limit) w_state_nxt = ST_STOP;
      ST_STOP: if (w_rise) w_state_nxt = ST_MEAS;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_at_limit = (r_cnt == LP_TIMEOUT);
    w_count_en = (r_state == ST_MEAS) && !w_at_limit;
    w_load     = (r_state == ST_MEAS) && w_rise && (!r_valid || meas_ready);
    w_drop     = (r_state == ST_MEAS) && w_rise && r_valid && !meas_ready;
    stopped    = (r_state == ST_STOP);
  end

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n)        r_cnt <= '0;
    else if (w_rise)     r_cnt <= LP_ONE;
    else if (w_count_en) r_cnt <= r_cnt + LP_ONE;
  end

  // A completed measurement may overwrite the one being transferred this cycle.
  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      r_valid   <= 1'b0;
      r_period  <= '0;
      r_dropped <= 1'b0;
    end else begin
      r_dropped <= w_drop;
      if (w_load) begin
        r_valid  <= 1'b1;
        r_period <= r_cnt;
      end else if (r_valid && meas_ready) begin
        r_valid <= 1'b0;
      end
    end
  end

`ifdef DUTY_MEASURE_EN
  logic [CNT_W-1:0] r_hcnt;
  logic [CNT_W-1:0] r_high;

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n)        r_hcnt <= '0;
    else if (w_rise)     r_hcnt <= CNT_W'(w_s);
    else if (w_count_en) r_hcnt <= r_hcnt + CNT_W'(w_s);
  end

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n)    r_high <= '0;
    else if (w_load) r_high <= r_hcnt;
  end

  assign high_time = r_high;
`else
  logic w_unused_s;
  assign w_unused_s = w_s;
  assign high_time  = '0;
`endif

  assign meas_valid = r_valid;
  assign period     = r_period;
  assign dropped    = r_dropped;

endmodule
